// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl_pkg
// Description : Shared types and helpers for the RAM port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    // Controller phases: zero-fill sweep, then normal request traffic
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

    // Width of a counter that must hold every value 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ram_rsp_fifo
// Description : Shift-style response FIFO; entry 0 is the registered head.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rsp_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int BW        = 32,
    parameter int RSP_DEPTH = 4,
    localparam int CW       = cnt_width(RSP_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [BW-1:0] push_data,
    input  logic          pop,
    output logic [BW-1:0] head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [BW-1:0] mem [RSP_DEPTH];
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic [CW-1:0] wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CW'(RSP_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // A simultaneous pop shifts everything down one slot, so the write lands one lower
    assign wr_idx  = do_pop ? (count - 1'b1) : count;
    assign head    = mem[0];

    // Storage shift on pop, then write of the new entry (later assignment wins)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < RSP_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                for (int i = 0; i < RSP_DEPTH; i++) begin
                    if (wr_idx == CW'(i)) begin
                        mem[i] <= push_data;
                    end
                end
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must never let a push hit a full FIFO
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop));

endmodule
`default_nettype wire

// File: rtl/ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_ctrl
// Description : Valid/ready front-end for a single-port RAM with optional
//               zero-fill after reset and in-order read response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int BW             = 32,
    parameter int AW             = 10,
    parameter int RSP_DEPTH      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [BW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [BW-1:0] rsp_rdata,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [BW-1:0] ram_data_in,
    input  logic [BW-1:0] ram_data_out
);

    localparam int          CW          = cnt_width(RSP_DEPTH);
    localparam ctrl_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    ctrl_state_t   state;
    ctrl_state_t   state_d;
    logic [AW-1:0] clr_cnt;
    logic          rd_inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [CW:0]   occupancy;
    logic          credit;
    logic          rd_accept;

    // Credit uses registered occupancy only; a same-cycle pop does not free a slot
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(rd_inflight);
    assign credit    = (occupancy < (CW+1)'(RSP_DEPTH));
    assign rd_accept = req_valid & req_ready & ~req_we;
    assign rsp_valid = ~fifo_empty;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_d;
    end

    // Next state and RAM/handshake outputs; RAM strobes are muted while reset is held
    always_comb begin
        state_d     = state;
        busy        = 1'b0;
        req_ready   = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = req_addr;
        ram_data_in = req_wdata;
        case (state)
            CLEAR: begin
                busy        = 1'b1;
                ram_we      = ~rst;
                ram_addr    = clr_cnt;
                ram_data_in = '0;
                if (clr_cnt == '1) state_d = RUN;
            end
            RUN: begin
                req_ready = req_we | credit;
                ram_we    = ~rst & req_valid & req_ready & req_we;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Clear sweep address, advancing once per cycle while clearing
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    // One-cycle marker that RAM read data is due on the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_inflight <= 1'b0;
        else     rd_inflight <= rd_accept;
    end

    ram_rsp_fifo #(
        .BW        (BW),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight),
        .push_data (ram_data_out),
        .pop       (rsp_valid & rsp_ready),
        .head      (rsp_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_ctrl
// Description : Directed self-checking bench for ram_port_ctrl with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_ctrl;

    localparam int BW        = 32;
    localparam int AW        = 4;
    localparam int RSP_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [BW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [BW-1:0] rsp_rdata;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_data_in;
    logic [BW-1:0] ram_data_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [BW-1:0] got[$];
    int            got_cyc[$];

    ram_port_ctrl #(
        .BW             (BW),
        .AW             (AW),
        .RSP_DEPTH      (RSP_DEPTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model (read returns pre-write contents)
    logic [BW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data_in;
        ram_data_out <= ram_mem[ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every response handshake that the next edge will complete
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            got.push_back(rsp_rdata);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request; acc_edge is the edge number at which it is accepted
    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [BW-1:0] d, output int acc_edge);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        acc_edge = cyc + 1;
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: req_ready=%0b required 1 (addr %0d)", req_ready, a);
            acc_edge = -1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 50 && got.size() < n; k++) tick(1);
        checks++;
        if (got.size() != n) begin
            failures++;
            $display("FAIL rsp_count: got %0d responses required %0d", got.size(), n);
        end
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: %0b required 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0) begin failures++; $display("FAIL rst_rsp_rdata: %0h required 0", rsp_rdata); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy: %0b required 1", busy); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we: %0b required 0", ram_we); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: %0b required 0", req_ready); end
    endtask

    task automatic test_clear;
        int e;
        rst = 1'b0;
        #1;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(c) || ram_data_in !== '0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL clear_cycle%0d: busy=%0b we=%0b addr=%0d din=%0h rdy=%0b required 1 1 %0d 0 0",
                         c, busy, ram_we, ram_addr, ram_data_in, req_ready, c);
            end
            @(posedge clk);
            #1;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_done_busy: %0b required 0", busy); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL clear_done_ready: %0b required 1", req_ready); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL clear_done_we: %0b required 0", ram_we); end
        rsp_ready = 1'b1;
        got.delete(); got_cyc.delete();
        for (int a = 0; a < 16; a++) do_req(1'b0, AW'(a), '0, e);
        wait_rsp(16);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== '0) begin failures++; $display("FAIL clear_read%0d: %0h required 0", i, got[i]); end
        end
    endtask

    task automatic test_raw;
        int e0, e1;
        rsp_ready = 1'b1;
        got.delete(); got_cyc.delete();
        do_req(1'b1, 4'd3, 32'hDEADBEEF, e0);
        do_req(1'b0, 4'd3, '0, e1);
        checks++; if (e1 != e0 + 1) begin failures++; $display("FAIL raw_accept: edge %0d required %0d", e1, e0 + 1); end
        wait_rsp(1);
        if (got.size() > 0) begin
            checks++; if (got[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_data: %0h required deadbeef", got[0]); end
            checks++; if (got_cyc[0] != e1 + 1) begin failures++; $display("FAIL raw_latency: cycle %0d required %0d", got_cyc[0], e1 + 1); end
        end
    endtask

    task automatic test_back_to_back;
        int w[8];
        int r[8];
        rsp_ready = 1'b1;
        for (int a = 0; a < 8; a++) do_req(1'b1, AW'(a), BW'(a), w[a]);
        checks++; if (w[7] != w[0] + 7) begin failures++; $display("FAIL b2b_writes: last edge %0d required %0d", w[7], w[0] + 7); end
        got.delete(); got_cyc.delete();
        for (int a = 0; a < 8; a++) do_req(1'b0, AW'(a), '0, r[a]);
        checks++; if (r[7] != r[0] + 7) begin failures++; $display("FAIL b2b_reads: last edge %0d required %0d", r[7], r[0] + 7); end
        wait_rsp(8);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== BW'(i) || got_cyc[i] != r[0] + 1 + i) begin
                failures++;
                $display("FAIL b2b_rsp%0d: data %0h cycle %0d required %0h cycle %0d",
                         i, got[i], got_cyc[i], i, r[0] + 1 + i);
            end
        end
    endtask

    task automatic test_backpressure;
        int e;
        rsp_ready = 1'b0;
        got.delete(); got_cyc.delete();
        for (int a = 0; a < 4; a++) do_req(1'b0, AW'(a), '0, e);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_read_stall: %0b required 0", req_ready); end
        req_we = 1'b1; req_addr = 4'd10; req_wdata = 32'hA5A50001;
        #1;
        checks++; if (req_ready !== 1'b1 || ram_we !== 1'b1) begin failures++; $display("FAIL bp_write_ok: rdy=%0b we=%0b required 1 1", req_ready, ram_we); end
        req_valid = 1'b0;
        do_req(1'b1, 4'd10, 32'hA5A50001, e);
        tick(3);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_still_stalled: %0b required 0", req_ready); end
        req_valid = 1'b0;
        checks++; if (dut.u_fifo.count !== 3'd4) begin failures++; $display("FAIL bp_count: %0d required 4", dut.u_fifo.count); end
        checks++; if (got.size() != 0) begin failures++; $display("FAIL bp_no_pop: %0d required 0", got.size()); end
        rsp_ready = 1'b1;
        wait_rsp(4);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== BW'(i)) begin failures++; $display("FAIL bp_rsp%0d: %0h required %0h", i, got[i], i); end
        end
        got.delete(); got_cyc.delete();
        do_req(1'b0, 4'd10, '0, e);
        wait_rsp(1);
        if (got.size() > 0) begin
            checks++; if (got[0] !== 32'hA5A50001) begin failures++; $display("FAIL bp_write_data: %0h required a5a50001", got[0]); end
        end
    endtask

    task automatic test_pop_push;
        int e;
        rsp_ready = 1'b0;
        got.delete(); got_cyc.delete();
        for (int a = 4; a < 7; a++) do_req(1'b0, AW'(a), '0, e);
        tick(2);
        checks++; if (dut.u_fifo.count !== 3'd3) begin failures++; $display("FAIL pp_pre_count: %0d required 3", dut.u_fifo.count); end
        do_req(1'b0, 4'd7, '0, e);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dut.u_fifo.count !== 3'd3) begin failures++; $display("FAIL pp_count: %0d required 3", dut.u_fifo.count); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd5) begin failures++; $display("FAIL pp_head: valid=%0b data=%0h required 1 5", rsp_valid, rsp_rdata); end
        wait_rsp(4);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== BW'(i + 4)) begin failures++; $display("FAIL pp_rsp%0d: %0h required %0h", i, got[i], i + 4); end
        end
    endtask

    task automatic test_reset_midop;
        int e;
        int stale;
        int not_busy;
        rsp_ready = 1'b0;
        got.delete(); got_cyc.delete();
        for (int a = 0; a < 3; a++) do_req(1'b0, AW'(a), '0, e);
        checks++; if (dut.u_fifo.count !== 3'd2 || dut.rd_inflight !== 1'b1) begin
            failures++; $display("FAIL mid_setup: count=%0d inflight=%0b required 2 1", dut.u_fifo.count, dut.rd_inflight); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid: %0b required 0", rsp_valid); end
        checks++; if (busy !== 1'b1 || ram_we !== 1'b0 || req_ready !== 1'b0) begin
            failures++; $display("FAIL mid_rst_out: busy=%0b we=%0b rdy=%0b required 1 0 0", busy, ram_we, req_ready); end
        rsp_ready = 1'b1;
        tick(2);
        rst = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== '0) begin failures++; $display("FAIL mid_clear_restart: we=%0b addr=%0d required 1 0", ram_we, ram_addr); end
        stale = 0;
        not_busy = 0;
        for (int c = 0; c < 16; c++) begin
            if (rsp_valid !== 1'b0) stale++;
            if (busy !== 1'b1) not_busy++;
            @(posedge clk);
            #1;
        end
        checks++; if (stale != 0 || got.size() != 0) begin failures++; $display("FAIL mid_stale: valid cycles %0d responses %0d required 0 0", stale, got.size()); end
        checks++; if (not_busy != 0 || busy !== 1'b0) begin failures++; $display("FAIL mid_clear_len: idle cycles %0d busy=%0b required 0 0", not_busy, busy); end
        do_req(1'b0, 4'd1, '0, e);
        wait_rsp(1);
        if (got.size() > 0) begin
            checks++; if (got[0] !== '0) begin failures++; $display("FAIL mid_cleared: %0h required 0", got[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_raw();
        test_back_to_back();
        test_backpressure();
        test_pop_push();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
